// File: rtl/montgomery_reduce_pipe.sv
// montgomery_reduce_pipe
//   Three-stage pipelined Montgomery reduction: result = x * 2^-K mod m.
//   The modulus m, its negated inverse minv = -m^-1 mod 2^K and the bit
//   length K are loaded at runtime through a config handshake that is only
//   accepted while the pipeline is empty. Operands carry a sideband tag that
//   comes back out with the matching result, in order.
//
// Ports
//   clk_i, rst_ni              clock, asynchronous active-low reset
//   cfg_valid_i / cfg_ready_o  config write handshake (ready = pipeline empty)
//   m_i, minv_i, m_bl_i        modulus (odd), -m^-1 mod 2^K, K in 1..DATA_LENGTH
//   cfg_err_o                  one-cycle pulse after a rejected config write
//   in_valid_i / in_ready_o    operand handshake; x_i < m*2^K, tag_i sideband
//   out_valid_o / out_ready_i  result handshake; result_o in 0..m-1, tag_o
//   busy_o                     any pipeline stage holds valid data
//
// Note: the operand path does not look at cfg_valid_i, so upstream must not
// present an operand in the same cycle as a config write; otherwise stage 1
// would use the old config while stages 2/3 use the new one.
module montgomery_reduce_pipe #(
  parameter int DATA_LENGTH = 32,
  parameter int TAG_WIDTH   = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     cfg_valid_i,
  output logic                     cfg_ready_o,
  input  logic [DATA_LENGTH-1:0]   m_i,
  input  logic [DATA_LENGTH-1:0]   minv_i,
  input  logic [DATA_LENGTH-1:0]   m_bl_i,
  output logic                     cfg_err_o,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [2*DATA_LENGTH-1:0] x_i,
  input  logic [TAG_WIDTH-1:0]     tag_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [DATA_LENGTH-1:0]   result_o,
  output logic [TAG_WIDTH-1:0]     tag_o,
  output logic                     busy_o
);

  localparam int KW = $clog2(DATA_LENGTH + 1);
  localparam int XW = 2 * DATA_LENGTH;
  localparam int SW = XW + 1;
  localparam logic [DATA_LENGTH-1:0] MAX_K = DATA_LENGTH'(DATA_LENGTH);

  // Final correction: r < 2m on entry, one conditional subtract brings it into 0..m-1.
  function automatic logic [DATA_LENGTH-1:0] cond_sub(
    input logic [DATA_LENGTH:0]   r,
    input logic [DATA_LENGTH-1:0] m
  );
    logic [DATA_LENGTH:0] m_ext;
    m_ext = {1'b0, m};
    if (r >= m_ext) return DATA_LENGTH'(r - m_ext);
    else            return r[DATA_LENGTH-1:0];
  endfunction

  // Configuration state
  logic [DATA_LENGTH-1:0] m_q;
  logic [DATA_LENGTH-1:0] minv_q;
  logic [KW-1:0]          k_q;
  logic                   cfg_loaded_q;
  logic                   cfg_err_q;

  // Pipeline control and data
  logic                   vld_p1, vld_p2, vld_p3;
  logic                   adv1, adv2, adv3;
  logic [XW-1:0]          x_p1;
  logic [TAG_WIDTH-1:0]   tag_p1;
  logic [DATA_LENGTH-1:0] q_p1;
  logic [SW-1:0]          s_p2;
  logic [TAG_WIDTH-1:0]   tag_p2;
  logic [DATA_LENGTH-1:0] result_p3;
  logic [TAG_WIDTH-1:0]   tag_p3;

  logic                   cfg_fire;
  logic                   cfg_bad;
  logic                   in_fire;
  logic [DATA_LENGTH-1:0] k_mask;
  logic [DATA_LENGTH-1:0] x_lo;
  logic [DATA_LENGTH-1:0] q_next;
  logic [XW-1:0]          qm;
  logic [SW-1:0]          s_next;
  logic [DATA_LENGTH:0]   r_raw;
  logic [DATA_LENGTH-1:0] r_next;

  assign busy_o      = vld_p1 | vld_p2 | vld_p3;
  assign cfg_ready_o = ~busy_o;
  assign cfg_fire    = cfg_valid_i & cfg_ready_o;
  assign cfg_bad     = (m_bl_i == '0) | (m_bl_i > MAX_K) | ~m_i[0];

  assign adv3 = ~vld_p3 | out_ready_i;
  assign adv2 = ~vld_p2 | adv3;
  assign adv1 = ~vld_p1 | adv2;

  assign in_ready_o = cfg_loaded_q & adv1;
  assign in_fire    = in_valid_i & in_ready_o;

  // Shifting all-ones by K = DATA_LENGTH yields zero, so the mask becomes all-ones.
  assign k_mask = ~({DATA_LENGTH{1'b1}} << k_q);

  // Stage 1 combinational: q = (x mod 2^K) * minv mod 2^K
  assign x_lo   = x_i[DATA_LENGTH-1:0] & k_mask;
  assign q_next = DATA_LENGTH'(x_lo * minv_q) & k_mask;

  // Stage 2 combinational: s = x + q*m, kept full width (s < 2*m*2^K)
  assign qm     = {{DATA_LENGTH{1'b0}}, q_p1} * {{DATA_LENGTH{1'b0}}, m_q};
  assign s_next = {1'b0, x_p1} + {1'b0, qm};

  // Stage 3 combinational: s is divisible by 2^K, so the shift is exact and r < 2m
  assign r_raw  = (DATA_LENGTH + 1)'(s_p2 >> k_q);
  assign r_next = cond_sub(r_raw, m_q);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      m_q          <= '0;
      minv_q       <= '0;
      k_q          <= '0;
      cfg_loaded_q <= 1'b0;
      cfg_err_q    <= 1'b0;
    end else begin
      cfg_err_q <= cfg_fire & cfg_bad;
      if (cfg_fire && !cfg_bad) begin
        m_q          <= m_i;
        minv_q       <= minv_i;
        k_q          <= m_bl_i[KW-1:0];
        cfg_loaded_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
      vld_p3 <= 1'b0;
    end else begin
      if (adv1) vld_p1 <= in_fire;
      if (adv2) vld_p2 <= vld_p1;
      if (adv3) vld_p3 <= vld_p2;
    end
  end

  // ---- stage 1 boundary ----
  always_ff @(posedge clk_i) begin
    if (in_fire) begin
      x_p1   <= x_i;
      tag_p1 <= tag_i;
      q_p1   <= q_next;
    end
  end

  // ---- stage 2 boundary ----
  always_ff @(posedge clk_i) begin
    if (adv2 && vld_p1) begin
      s_p2   <= s_next;
      tag_p2 <= tag_p1;
    end
  end

  // ---- stage 3 boundary (drives the outputs, so it has defined reset values) ----
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      result_p3 <= '0;
      tag_p3    <= '0;
    end else if (adv3 && vld_p2) begin
      result_p3 <= r_next;
      tag_p3    <= tag_p2;
    end
  end

  assign out_valid_o = vld_p3;
  assign result_o    = result_p3;
  assign tag_o       = tag_p3;
  assign cfg_err_o   = cfg_err_q;

endmodule

// File: doc/montgomery_reduce_pipe.md
Name: montgomery_reduce_pipe

Overview:
Pipelined, parametrised Montgomery reduction engine. It is the sequential successor to the combinational montgomery_parallel and is intended for the Dilithium/Kyber NTT datapath. Modulus, inverse and bit-length are runtime-loadable through a config handshake. Operands stream in and results stream out over valid/ready with full backpressure, and a sideband tag travels with each operand.

Parameters:
DATA_LENGTH, 32, maximum modulus width in bits; result width.
TAG_WIDTH, 8, width of the sideband tag carried alongside each operand.

Ports:
clk_i  in  1  rising-edge clock.
rst_ni  in  1  reset, asynchronous, active-low.
cfg_valid_i  in  1  config write request.
cfg_ready_o  out  1  config may be accepted (pipeline empty).
m_i  in  DATA_LENGTH  modulus m; odd.
minv_i  in  DATA_LENGTH  -m^-1 mod 2^K.
m_bl_i  in  DATA_LENGTH  K = modulus bit-length, 1..DATA_LENGTH.
cfg_err_o  out  1  one-cycle pulse: rejected config.
in_valid_i  in  1  operand valid.
in_ready_o  out  1  operand accepted when valid and ready are both high.
x_i  in  2*DATA_LENGTH  operand; must satisfy x < m*2^K.
tag_i  in  TAG_WIDTH  sideband tag.
out_valid_o  out  1  result valid.
out_ready_i  in  1  downstream ready.
result_o  out  DATA_LENGTH  x*2^-K mod m, in the range 0..m-1.
tag_o  out  TAG_WIDTH  tag of the result.
busy_o  out  1  any pipeline stage holds valid data.

Behaviour:
- Reset: all stage valids clear; config registers clear; cfg_loaded=0.
- Reset values of outputs: out_valid_o=0, result_o=0, tag_o=0, busy_o=0, in_ready_o=0, cfg_err_o=0, cfg_ready_o=1.
- Config: accepted on cfg_valid_i & cfg_ready_o. cfg_ready_o = !busy_o.
  - If m_bl_i==0, m_bl_i>DATA_LENGTH, or m_i[0]==0: config regs unchanged; cfg_err_o pulses the next cycle.
  - Otherwise m, minv, K are registered and cfg_loaded=1 from the next cycle.
  - cfg_valid_i while busy: ignored, no error pulse.
- in_ready_o = cfg_loaded & (!v1 | adv1). No operands are accepted before the first valid config.
- Stage 1 registers x, tag, and q = (x mod 2^K * minv) mod 2^K. Masking uses a runtime mask of (1<<K)-1.
- Stage 2 registers s = x + q*m. Width is 2*DATA_LENGTH+1 bits; no truncation is allowed.
- Stage 3 registers r = s >> K; if r >= m then r = r - m. result_o and tag_o come directly from stage-3 registers.
- Stall logic:
  - adv3 = !v3 | out_ready_i; adv2 = !v2 | adv3; adv1 = !v1 | adv2.
  - A stage loads only when it advances, and keeps its data otherwise.
  - No bubbles are inserted and no data is lost under backpressure.
- Latency: 3 cycles from acceptance to out_valid_o when there is no backpressure. Throughput is one result per cycle.
- Outputs are held stable while out_valid_o=1 and out_ready_i=0.
- Simultaneous accept and emit in the same cycle: both take effect.
- Order preserved; tags are returned in input order.
- Reset mid-operation: in-flight data is discarded, no output is produced, and config is lost; a reload is required.
- Operands with x >= m*2^K produce undefined data. Handshake behaviour is unaffected.

Test Plan:
- Config rejection: send m=8380418 (even), then m_bl=0 -> cfg_err_o pulses once each time; in_ready_o stays 0.
- Basic reduction: load m=8380417, minv=8380415, K=23. Send x=5*2^23=41943040 with tag 0x11 -> result 5, tag 0x11, exactly 3 cycles after acceptance.
- Subtract path and zero: x=8380417 -> 0 (final subtract taken); x=0 -> 0; x=8380416*2^23 -> 8380416.
- Streaming with backpressure:
  - 1000 random x < m*2^23 back-to-back, with out_ready_i toggled randomly.
  - Every result must equal x*2^-23 mod m from the software model, in order, with matching tags.
  - No duplicates or drops; held outputs must not change while stalled.
- Config while busy: assert cfg_valid_i with 2 operands in flight -> cfg_ready_o=0 and config unchanged. After the pipeline drains, load K=12, m=3329 (Kyber), minv=-3329^-1 mod 2^12. Send x=7*4096 -> result 7.
- Reset mid-stream: pull rst_ni low for 1 cycle with 3 valid stages -> out_valid_o=0 and busy_o=0 immediately, in_ready_o=0 until reconfigured, and no stale result appears after reconfiguration.
